gate_controller: RTL and testbench

- Front end of the parking system. Owns the entry and exit barriers and debounces the raw vehicle-loop sensors.
- Produces the single-cycle car_in / car_out event pulses that the occupancy counter consumes. Reads that counter's parking_full flag back to refuse entry.
- Sits between the physical sensor inputs and the parking occupancy logic, in the same clock domain.

---
 rtl/gate_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_gate_controller.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_controller.sv
// gate_controller: parking front end. Debounces the four vehicle-loop sensors,
// runs one barrier FSM per gate and emits car_in / car_out event pulses.
// Optional feature macro PASS_TIMEOUT_EN: a barrier left waiting in WAIT_PASS
// for PASS_TIMEOUT cycles closes without a pulse and sets sticky timeout_flag.
module gate_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TRAVEL_CYCLES   = 8,
  parameter int unsigned PASS_TIMEOUT    = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic entry_arrive,
  input  logic entry_pass,
  input  logic exit_arrive,
  input  logic exit_pass,
  input  logic parking_full,
  output logic car_in,
  output logic car_out,
  output logic entry_gate_open,
  output logic exit_gate_open,
  output logic entry_denied,
  output logic timeout_flag
);

  localparam int unsigned DW      = $clog2(DEBOUNCE_CYCLES + 1);
  // One counter per gate times both travel and the pass timeout; without the
  // timeout feature its upper bits never toggle and are trimmed away.
  localparam int unsigned CNT_MAX = (TRAVEL_CYCLES > PASS_TIMEOUT) ? TRAVEL_CYCLES : PASS_TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam int unsigned S_EN_ARR  = 0;
  localparam int unsigned S_EN_PASS = 1;
  localparam int unsigned S_EX_ARR  = 2;
  localparam int unsigned S_EX_PASS = 3;

  typedef enum logic [1:0] {IDLE, OPENING, WAIT_PASS, CLOSING} gate_state_e;

  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q, deb_q;
  logic [DW-1:0] dcnt_q [4];
  logic          en_pass_prev_q, ex_pass_prev_q;
  logic          en_pass_rise, ex_pass_rise;

  gate_state_e   en_state_q, ex_state_q;
  logic [CW-1:0] en_cnt_q, ex_cnt_q;
  logic          en_open_q, ex_open_q, en_denied_q;
  logic          en_req, ex_req, en_tmo, ex_tmo;

  logic          car_in_q, car_out_q, in_pending_q;

  assign raw = {exit_pass, exit_arrive, entry_pass, entry_arrive};

  // Synchronize, debounce and keep the previous debounced pass levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      deb_q          <= '0;
      en_pass_prev_q <= 1'b0;
      ex_pass_prev_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q        <= raw;
      sync2_q        <= sync1_q;
      en_pass_prev_q <= deb_q[S_EN_PASS];
      ex_pass_prev_q <= deb_q[S_EX_PASS];
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i]  <= sync2_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign en_pass_rise = deb_q[S_EN_PASS] & ~en_pass_prev_q;
  assign ex_pass_rise = deb_q[S_EX_PASS] & ~ex_pass_prev_q;
  assign en_req       = (en_state_q == WAIT_PASS) && en_pass_rise;
  assign ex_req       = (ex_state_q == WAIT_PASS) && ex_pass_rise;

`ifdef PASS_TIMEOUT_EN
  logic timeout_q;

  assign en_tmo = (en_state_q == WAIT_PASS) && !en_pass_rise && (en_cnt_q == CW'(PASS_TIMEOUT - 1));
  assign ex_tmo = (ex_state_q == WAIT_PASS) && !ex_pass_rise && (ex_cnt_q == CW'(PASS_TIMEOUT - 1));

  // Sticky record that a barrier was forced closed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  timeout_q <= 1'b0;
    else if (en_tmo || ex_tmo) timeout_q <= 1'b1;
  end

  assign timeout_flag = timeout_q;
`else
  assign en_tmo       = 1'b0;
  assign ex_tmo       = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // Entry barrier FSM; parking_full only gates the IDLE -> OPENING decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_state_q  <= IDLE;
      en_cnt_q    <= '0;
      en_open_q   <= 1'b0;
      en_denied_q <= 1'b0;
    end else begin
      case (en_state_q)
        IDLE: begin
          en_cnt_q <= '0;
          if (en_denied_q) begin
            // Refusal is withdrawn first; the barrier may open on the next edge.
            if (!deb_q[S_EN_ARR] || !parking_full) en_denied_q <= 1'b0;
          end else if (deb_q[S_EN_ARR]) begin
            if (parking_full) begin
              en_denied_q <= 1'b1;
            end else begin
              en_state_q <= OPENING;
              en_open_q  <= 1'b1;
            end
          end
        end
        OPENING: begin
          if (en_cnt_q == CW'(TRAVEL_CYCLES - 1)) begin
            en_state_q <= WAIT_PASS;
            en_cnt_q   <= '0;
          end else begin
            en_cnt_q <= en_cnt_q + CW'(1);
          end
        end
        WAIT_PASS: begin
          if (en_req || en_tmo) begin
            en_state_q <= CLOSING;
            en_open_q  <= 1'b0;
            en_cnt_q   <= '0;
          end else begin
`ifdef PASS_TIMEOUT_EN
            en_cnt_q <= en_cnt_q + CW'(1);
`else
            en_cnt_q <= '0;
`endif
          end
        end
        default: begin
          if (en_cnt_q == CW'(TRAVEL_CYCLES - 1)) begin
            en_state_q <= IDLE;
            en_cnt_q   <= '0;
          end else begin
            en_cnt_q <= en_cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Exit barrier FSM; never refused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_state_q <= IDLE;
      ex_cnt_q   <= '0;
      ex_open_q  <= 1'b0;
    end else begin
      case (ex_state_q)
        IDLE: begin
          ex_cnt_q <= '0;
          if (deb_q[S_EX_ARR]) begin
            ex_state_q <= OPENING;
            ex_open_q  <= 1'b1;
          end
        end
        OPENING: begin
          if (ex_cnt_q == CW'(TRAVEL_CYCLES - 1)) begin
            ex_state_q <= WAIT_PASS;
            ex_cnt_q   <= '0;
          end else begin
            ex_cnt_q <= ex_cnt_q + CW'(1);
          end
        end
        WAIT_PASS: begin
          if (ex_req || ex_tmo) begin
            ex_state_q <= CLOSING;
            ex_open_q  <= 1'b0;
            ex_cnt_q   <= '0;
          end else begin
`ifdef PASS_TIMEOUT_EN
            ex_cnt_q <= ex_cnt_q + CW'(1);
`else
            ex_cnt_q <= '0;
`endif
          end
        end
        default: begin
          if (ex_cnt_q == CW'(TRAVEL_CYCLES - 1)) begin
            ex_state_q <= IDLE;
            ex_cnt_q   <= '0;
          end else begin
            ex_cnt_q <= ex_cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Event pulses: car_out wins a tie, car_in is deferred one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_in_q     <= 1'b0;
      car_out_q    <= 1'b0;
      in_pending_q <= 1'b0;
    end else begin
      car_out_q <= ex_req;
      if (ex_req) begin
        car_in_q     <= 1'b0;
        in_pending_q <= in_pending_q | en_req;
      end else begin
        car_in_q     <= in_pending_q | en_req;
        in_pending_q <= 1'b0;
      end
    end
  end

  assign car_in          = car_in_q;
  assign car_out         = car_out_q;
  assign entry_gate_open = en_open_q;
  assign exit_gate_open  = ex_open_q;
  assign entry_denied    = en_denied_q;

endmodule

// File: tb/tb_gate_controller.sv
// Bench for gate_controller: scenario tasks with randomized timing, expected
// cycle numbers derived from the debounce/travel/timeout rules.
module tb_gate_controller;

  localparam int unsigned DEB  = 4;
  localparam int unsigned TRAV = 8;
  localparam int unsigned PTO  = 64;
  // Clean input change -> debounced level on edge 2+DEB -> FSM reacts one edge later.
  localparam int unsigned T_REACT = 2 + DEB + 1;
  localparam int unsigned T_WAIT  = T_REACT + TRAV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic entry_arrive = 1'b0, entry_pass = 1'b0, exit_arrive = 1'b0, exit_pass = 1'b0;
  logic parking_full = 1'b0;
  logic car_in, car_out, entry_gate_open, exit_gate_open, entry_denied, timeout_flag;

  int tests_run = 0;
  int fails     = 0;
  int n_in      = 0;
  int n_out     = 0;
  int n_both    = 0;

  gate_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .TRAVEL_CYCLES  (TRAV),
    .PASS_TIMEOUT   (PTO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .entry_arrive   (entry_arrive),
    .entry_pass     (entry_pass),
    .exit_arrive    (exit_arrive),
    .exit_pass      (exit_pass),
    .parking_full   (parking_full),
    .car_in         (car_in),
    .car_out        (car_out),
    .entry_gate_open(entry_gate_open),
    .exit_gate_open (exit_gate_open),
    .entry_denied   (entry_denied),
    .timeout_flag   (timeout_flag)
  );

  always #5 clk = ~clk;

  // Pulse tally, sampled shortly after each active edge.
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (car_in)            n_in++;
      if (car_out)           n_out++;
      if (car_in && car_out) n_both++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    entry_arrive = 1'b0; entry_pass = 1'b0;
    exit_arrive  = 1'b0; exit_pass  = 1'b0;
    parking_full = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({car_in, car_out, entry_gate_open, exit_gate_open, entry_denied, timeout_flag} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 000000",
               {car_in, car_out, entry_gate_open, exit_gate_open, entry_denied, timeout_flag});
    end
    do_reset();
    tick(3);
    tests_run++;
    if ({car_in, car_out, entry_gate_open, exit_gate_open, entry_denied, timeout_flag} !== 6'b0) begin
      fails++;
      $display("FAIL post_reset_idle: got %b want 000000",
               {car_in, car_out, entry_gate_open, exit_gate_open, entry_denied, timeout_flag});
    end
  endtask

  task automatic test_normal_entry();
    int k, t, in0;
    do_reset();
    k   = int'($urandom_range(T_WAIT - T_REACT + 1, 20));
    in0 = n_in;
    entry_arrive = 1'b1;
    t = 0;
    tick(T_REACT - 1); t += T_REACT - 1;
    tests_run++;
    if (entry_gate_open !== 1'b0) begin fails++; $display("FAIL entry_open_early: got %b want 0", entry_gate_open); end
    tick(1); t++;
    tests_run++;
    if (entry_gate_open !== 1'b1) begin fails++; $display("FAIL entry_open_edge: got %b want 1", entry_gate_open); end
    tick(2); t += 2;
    parking_full = 1'b1;   // going full after admission must not abort the car
    tick(k - t); t = k;
    entry_pass = 1'b1;
    tick(T_REACT - 1); t += T_REACT - 1;
    tests_run++;
    if ({entry_gate_open, car_in} !== 2'b10) begin
      fails++; $display("FAIL entry_before_pass: got open,car_in=%b want 10", {entry_gate_open, car_in});
    end
    tick(1); t++;
    tests_run++;
    if ({entry_gate_open, car_in} !== 2'b01) begin
      fails++; $display("FAIL entry_pass_pulse: got open,car_in=%b want 01 (k=%0d)", {entry_gate_open, car_in}, k);
    end
    tick(1); t++;
    parking_full = 1'b0;
    tests_run++;
    if (car_in !== 1'b0) begin fails++; $display("FAIL entry_pulse_width: got %b want 0", car_in); end
    tick(k + T_REACT + TRAV - t); t = k + T_REACT + TRAV;
    tests_run++;
    if (entry_gate_open !== 1'b0) begin fails++; $display("FAIL entry_closing: got %b want 0", entry_gate_open); end
    tick(1);
    tests_run++;
    if (entry_gate_open !== 1'b1) begin fails++; $display("FAIL entry_next_car: got %b want 1", entry_gate_open); end
    tests_run++;
    if (n_in - in0 !== 1) begin fails++; $display("FAIL entry_pulse_count: got %0d want 1", n_in - in0); end
  endtask

  task automatic test_pass_early();
    int k, in0;
    do_reset();
    k   = int'($urandom_range(1, T_WAIT - T_REACT));
    in0 = n_in;
    entry_arrive = 1'b1;
    tick(k);
    entry_pass = 1'b1;
    tick(10);
    entry_arrive = 1'b0;
    tick(40 - k - 10);
    tests_run++;
    if ({entry_gate_open, n_in - in0 == 0} !== 2'b11) begin
      fails++; $display("FAIL pass_outside_wait: got open=%b pulses=%0d want open=1 pulses=0 (k=%0d)",
                        entry_gate_open, n_in - in0, k);
    end
  endtask

  task automatic test_full_garage();
    int hold, bad;
    do_reset();
    hold = int'($urandom_range(25, 35));
    bad  = 0;
    parking_full = 1'b1;
    entry_arrive = 1'b1;
    tick(T_REACT - 1);
    tests_run++;
    if (entry_denied !== 1'b0) begin fails++; $display("FAIL denied_early: got %b want 0", entry_denied); end
    tick(1);
    tests_run++;
    if (entry_denied !== 1'b1) begin fails++; $display("FAIL denied_edge: got %b want 1", entry_denied); end
    for (int i = 0; i < hold; i++) begin
      tick(1);
      if (entry_gate_open !== 1'b0 || entry_denied !== 1'b1) bad++;
    end
    tests_run++;
    if (bad !== 0) begin fails++; $display("FAIL denied_hold: got %0d bad cycles want 0", bad); end
    parking_full = 1'b0;
    tick(1);
    tests_run++;
    if ({entry_denied, entry_gate_open} !== 2'b00) begin
      fails++; $display("FAIL denied_release: got denied,open=%b want 00", {entry_denied, entry_gate_open});
    end
    tick(1);
    tests_run++;
    if (entry_gate_open !== 1'b1) begin fails++; $display("FAIL open_after_release: got %b want 1", entry_gate_open); end
  endtask

  task automatic test_debounce();
    int len, bad, out0, t;
    do_reset();
    out0 = n_out;
    bad  = 0;
    len  = int'($urandom_range(1, DEB - 1));
    exit_arrive = 1'b1;
    tick(len);
    exit_arrive = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (exit_gate_open !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin fails++; $display("FAIL arrive_glitch: got %0d open cycles want 0 (len=%0d)", bad, len); end
    exit_arrive = 1'b1;
    tick(T_REACT);
    tests_run++;
    if (exit_gate_open !== 1'b1) begin fails++; $display("FAIL exit_open_edge: got %b want 1", exit_gate_open); end
    tick(2);
    exit_arrive = 1'b0;
    tick(T_WAIT + 1 - T_REACT - 2);
    t   = T_WAIT + 1;
    len = int'($urandom_range(1, DEB - 1));
    exit_pass = 1'b1;
    tick(len); t += len;
    exit_pass = 1'b0;
    tick(20); t += 20;
    tests_run++;
    if ({exit_gate_open, n_out - out0 == 0} !== 2'b11) begin
      fails++; $display("FAIL pass_glitch: got open=%b pulses=%0d want open=1 pulses=0", exit_gate_open, n_out - out0);
    end
    exit_pass = 1'b1;
    tick(DEB + 1);
    exit_pass = 1'b0;
    tick(T_REACT - DEB - 2);
    tests_run++;
    if (car_out !== 1'b0) begin fails++; $display("FAIL stable_pass_early: got %b want 0", car_out); end
    tick(1);
    tests_run++;
    if ({car_out, exit_gate_open} !== 2'b10) begin
      fails++; $display("FAIL stable_pass_pulse: got car_out,open=%b want 10", {car_out, exit_gate_open});
    end
    tick(1);
    tests_run++;
    if (n_out - out0 !== 1) begin fails++; $display("FAIL exit_pulse_count: got %0d want 1", n_out - out0); end
  endtask

  task automatic test_simultaneous();
    int k, in0, out0, both0;
    do_reset();
    k     = int'($urandom_range(T_WAIT - T_REACT + 1, 20));
    in0   = n_in;
    out0  = n_out;
    both0 = n_both;
    entry_arrive = 1'b1;
    exit_arrive  = 1'b1;
    tick(T_REACT + 2);
    entry_arrive = 1'b0;
    exit_arrive  = 1'b0;
    tick(k - T_REACT - 2);
    entry_pass = 1'b1;
    exit_pass  = 1'b1;
    tick(T_REACT);
    tests_run++;
    if ({car_out, car_in} !== 2'b10) begin fails++; $display("FAIL tie_cycle_n: got out,in=%b want 10", {car_out, car_in}); end
    tick(1);
    tests_run++;
    if ({car_out, car_in} !== 2'b01) begin fails++; $display("FAIL tie_cycle_n1: got out,in=%b want 01", {car_out, car_in}); end
    tick(1);
    tests_run++;
    if ({car_out, car_in} !== 2'b00) begin fails++; $display("FAIL tie_cycle_n2: got out,in=%b want 00", {car_out, car_in}); end
    tests_run++;
    if ({n_in - in0, n_out - out0, n_both - both0} !== {32'sd1, 32'sd1, 32'sd0}) begin
      fails++; $display("FAIL tie_counts: got in=%0d out=%0d both=%0d want 1 1 0",
                        n_in - in0, n_out - out0, n_both - both0);
    end
  endtask

  task automatic test_timeout();
    int out0, bad;
    do_reset();
    out0 = n_out;
    bad  = 0;
    exit_arrive = 1'b1;
    tick(T_REACT + 2);
    exit_arrive = 1'b0;
`ifdef PASS_TIMEOUT_EN
    tick(T_WAIT + PTO - 1 - T_REACT - 2);
    tests_run++;
    if ({exit_gate_open, timeout_flag} !== 2'b10) begin
      fails++; $display("FAIL timeout_before: got open,flag=%b want 10", {exit_gate_open, timeout_flag});
    end
    tick(1);
    tests_run++;
    if ({exit_gate_open, timeout_flag} !== 2'b01) begin
      fails++; $display("FAIL timeout_edge: got open,flag=%b want 01", {exit_gate_open, timeout_flag});
    end
    tick(100);
    tests_run++;
    if ({timeout_flag, n_out - out0 == 0} !== 2'b11) begin
      fails++; $display("FAIL timeout_sticky: got flag=%b pulses=%0d want 1 0", timeout_flag, n_out - out0);
    end
    do_reset();
    tests_run++;
    if (timeout_flag !== 1'b0) begin fails++; $display("FAIL timeout_cleared: got %b want 0", timeout_flag); end
`else
    for (int i = T_REACT + 2; i < 220; i++) begin
      tick(1);
      if (exit_gate_open !== 1'b1 || timeout_flag !== 1'b0) bad++;
    end
    tests_run++;
    if ({bad == 0, n_out - out0 == 0} !== 2'b11) begin
      fails++; $display("FAIL no_timeout_wait: got %0d bad cycles pulses=%0d want 0 0", bad, n_out - out0);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int in0;
    do_reset();
    entry_arrive = 1'b1;
    tick(T_REACT + 2);
    entry_arrive = 1'b0;
    tick(T_WAIT + 1 - T_REACT - 2);
    entry_pass = 1'b1;
    tick(T_REACT - 2);
    tests_run++;
    if (entry_gate_open !== 1'b1) begin fails++; $display("FAIL mid_open_before_rst: got %b want 1", entry_gate_open); end
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if ({car_in, car_out, entry_gate_open, exit_gate_open, entry_denied, timeout_flag} !== 6'b0) begin
      fails++; $display("FAIL mid_reset_async: got %b want 000000",
                        {car_in, car_out, entry_gate_open, exit_gate_open, entry_denied, timeout_flag});
    end
    tick(2);
    rst = 1'b0;
    in0 = n_in;
    tick(30);
    tests_run++;
    if ({n_in - in0 == 0, entry_gate_open} !== 2'b10) begin
      fails++; $display("FAIL mid_reset_no_pulse: got pulses=%0d open=%b want 0 0", n_in - in0, entry_gate_open);
    end
  endtask

  initial begin
    test_reset();
    for (int r = 0; r < 3; r++) test_normal_entry();
    test_pass_early();
    test_full_garage();
    test_debounce();
    for (int r = 0; r < 3; r++) test_simultaneous();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
